// File: rtl/bp_cache_dma_to_mem.sv
// Bridges a cache block DMA port to a beat-wide memory port: reads are streamed
// with bounded outstanding commands, writebacks are forwarded beat by beat.
module bp_cache_dma_to_mem #(
  parameter int unsigned caddr_width_p     = 28,
  parameter int unsigned fill_width_p      = 64,
  parameter int unsigned block_width_p     = 512,
  parameter int unsigned max_outstanding_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [caddr_width_p:0]   dma_pkt_i,
  input  logic                     dma_pkt_v_i,
  output logic                     dma_pkt_yumi_o,

  output logic [fill_width_p-1:0]  dma_data_o,
  output logic                     dma_data_v_o,
  input  logic                     dma_data_ready_and_i,

  input  logic [fill_width_p-1:0]  dma_data_i,
  input  logic                     dma_data_v_i,
  output logic                     dma_data_yumi_o,

  output logic                     mem_cmd_v_o,
  output logic                     mem_cmd_w_o,
  output logic [caddr_width_p-1:0] mem_cmd_addr_o,
  output logic [fill_width_p-1:0]  mem_cmd_data_o,
  input  logic                     mem_cmd_ready_and_i,

  input  logic [fill_width_p-1:0]  mem_resp_data_i,
  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_ready_and_o
);

  localparam int unsigned n_beats_lp      = block_width_p / fill_width_p;
  localparam int unsigned cnt_width_lp    = $clog2(n_beats_lp) + 1;
  localparam int unsigned offset_width_lp = $clog2(block_width_p / 8);
  localparam int unsigned beat_shift_lp   = $clog2(fill_width_p / 8);

  typedef enum logic [1:0] {
    e_idle,
    e_read,
    e_write
  } state_e;

  state_e                   state_r, state_n;
  logic [caddr_width_p-1:0] base_r, base_n;
  logic [cnt_width_lp-1:0]  issued_r, issued_n;
  logic [cnt_width_lp-1:0]  returned_r, returned_n;
  logic [cnt_width_lp-1:0]  outstanding;
  logic                     unused_pkt_offset;

  // Block offset bits of the packet address are dropped when aligning the base.
  assign unused_pkt_offset = ^dma_pkt_i[offset_width_lp-1:0];
  assign outstanding       = issued_r - returned_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      base_r     <= '0;
      issued_r   <= '0;
      returned_r <= '0;
    end else begin
      state_r    <= state_n;
      base_r     <= base_n;
      issued_r   <= issued_n;
      returned_r <= returned_n;
    end
  end

  // Next-state and handshake logic; everything is held quiet while reset is high.
  always_comb begin
    state_n              = state_r;
    base_n               = base_r;
    issued_n             = issued_r;
    returned_n           = returned_r;
    dma_pkt_yumi_o       = 1'b0;
    dma_data_o           = '0;
    dma_data_v_o         = 1'b0;
    dma_data_yumi_o      = 1'b0;
    mem_cmd_v_o          = 1'b0;
    mem_cmd_w_o          = 1'b0;
    mem_cmd_addr_o       = base_r + (caddr_width_p'(issued_r) << beat_shift_lp);
    mem_cmd_data_o       = '0;
    mem_resp_ready_and_o = 1'b0;

    if (!reset_i) begin
      unique case (state_r)
        e_idle: begin
          dma_pkt_yumi_o = dma_pkt_v_i;
          if (dma_pkt_v_i) begin
            base_n     = {dma_pkt_i[caddr_width_p-1:offset_width_lp], {offset_width_lp{1'b0}}};
            issued_n   = '0;
            returned_n = '0;
            state_n    = dma_pkt_i[caddr_width_p] ? e_write : e_read;
          end
        end

        e_read: begin
          mem_cmd_v_o          = (issued_r < cnt_width_lp'(n_beats_lp))
                                 && (32'(outstanding) < max_outstanding_p);
          dma_data_o           = mem_resp_data_i;
          dma_data_v_o         = mem_resp_v_i;
          mem_resp_ready_and_o = dma_data_ready_and_i;
          if (mem_cmd_v_o && mem_cmd_ready_and_i) begin
            issued_n = issued_r + cnt_width_lp'(1);
          end
          if (mem_resp_v_i && dma_data_ready_and_i) begin
            returned_n = returned_r + cnt_width_lp'(1);
            if (returned_r == cnt_width_lp'(n_beats_lp - 1)) begin
              state_n = e_idle;
            end
          end
        end

        e_write: begin
          mem_cmd_v_o     = dma_data_v_i;
          mem_cmd_w_o     = 1'b1;
          mem_cmd_data_o  = dma_data_i;
          dma_data_yumi_o = dma_data_v_i && mem_cmd_ready_and_i;
          if (dma_data_yumi_o) begin
            issued_n = issued_r + cnt_width_lp'(1);
            if (issued_r == cnt_width_lp'(n_beats_lp - 1)) begin
              state_n = e_idle;
            end
          end
        end

        default: state_n = e_idle;
      endcase
    end
  end

  // Memory responses are only legal while a read burst is in flight.
  resp_only_in_read_a: assert property (
    @(posedge clk_i) disable iff (reset_i) mem_resp_v_i |-> (state_r == e_read));

  outstanding_bound_a: assert property (
    @(posedge clk_i) disable iff (reset_i)
    (state_r == e_read) |-> (32'(outstanding) <= max_outstanding_p));

endmodule

// File: doc/bp_cache_dma_to_mem.md
BP_CACHE_DMA_TO_MEM -- requirements
Module: bp_cache_dma_to_mem

Interface
REQ-001 SHALL have parameter caddr_width_p, default 28, cache DMA byte-address width.
REQ-002 SHALL have parameter fill_width_p, default 64, bits per DMA data beat.
REQ-003 SHALL have parameter block_width_p, default 512, bits per cache block; N = block_width_p/fill_width_p beats, power of two, >= 2.
REQ-004 SHALL have parameter max_outstanding_p, default 4, maximum read beats issued but not yet returned.
REQ-005 SHALL have ports clk_i in 1, single clock; reset_i in 1, synchronous active-high reset.
REQ-006 SHALL have ports dma_pkt_i in 1+caddr_width_p, {write_not_read, addr}; dma_pkt_v_i in 1; dma_pkt_yumi_o out 1.
REQ-007 SHALL have ports dma_data_o out fill_width_p, fill beat to cache; dma_data_v_o out 1; dma_data_ready_and_i in 1.
REQ-008 SHALL have ports dma_data_i in fill_width_p, writeback beat from cache; dma_data_v_i in 1; dma_data_yumi_o out 1.
REQ-009 SHALL have ports mem_cmd_v_o out 1; mem_cmd_w_o out 1, 1 = write; mem_cmd_addr_o out caddr_width_p, byte address; mem_cmd_data_o out fill_width_p; mem_cmd_ready_and_i in 1.
REQ-010 SHALL have ports mem_resp_data_i in fill_width_p; mem_resp_v_i in 1; mem_resp_ready_and_o out 1; read responses in order, writes produce no response.

Function
REQ-011 SHALL implement FSM states IDLE, READ, WRITE.
REQ-012 IDLE: dma_pkt_yumi_o = dma_pkt_v_i; on acceptance SHALL latch base = addr with low log2(block_width_p/8) bits cleared, clear counters, go to READ or WRITE per write_not_read.
REQ-013 dma_pkt_yumi_o SHALL be 0 in READ and WRITE; a new packet is never accepted in the cycle a transfer completes (minimum one IDLE cycle between transfers).
REQ-014 Beat k address SHALL be base + k*(fill_width_p/8), k = 0..N-1, computed modulo 2^caddr_width_p.
REQ-015 READ: mem_cmd_v_o = 1, mem_cmd_w_o = 0 while issued < N and (issued - returned) < max_outstanding_p; issued increments on mem_cmd_v_o & mem_cmd_ready_and_i.
REQ-016 READ: dma_data_o = mem_resp_data_i, dma_data_v_o = mem_resp_v_i, mem_resp_ready_and_o = dma_data_ready_and_i, combinational pass-through, zero added latency; returned increments on mem_resp_v_i & dma_data_ready_and_i.
REQ-017 READ SHALL go to IDLE in the cycle after returned reaches N.
REQ-018 Issue and return in the same cycle SHALL leave the outstanding count unchanged.
REQ-019 WRITE: mem_cmd_v_o = dma_data_v_i, mem_cmd_w_o = 1, mem_cmd_data_o = dma_data_i, dma_data_yumi_o = dma_data_v_i & mem_cmd_ready_and_i; beat counter increments on yumi; go to IDLE after beat N-1 accepted.
REQ-020 Outside READ, dma_data_v_o and mem_resp_ready_and_o SHALL be 0; outside WRITE, dma_data_yumi_o SHALL be 0; in IDLE, mem_cmd_v_o SHALL be 0.
REQ-021 mem_resp_v_i asserted outside READ SHALL be a protocol violation flagged by a simulation assertion; it is not consumed.
REQ-022 Counters SHALL be log2(N)+1 bits; outstanding count SHALL never exceed max_outstanding_p.

Reset
REQ-023 On reset_i, FSM SHALL enter IDLE, all counters and latched base/op SHALL clear, and all valid/yumi/ready outputs SHALL be 0 in the cycle following reset assertion and during reset.
REQ-024 Reset mid-transfer SHALL abandon the transfer; the memory side is reset concurrently, so no stale responses are expected afterwards.

Verification
REQ-025 Read, addr 0x0000_0048, mem always ready, 1-cycle response -> mem addresses 0x40,0x48,...,0x78; 8 beats on dma_data_o in order; IDLE after 8th.
REQ-026 Read, mem response delayed 10 cycles -> exactly 4 cmds issued before first response; outstanding never > 4.
REQ-027 Write, addr 0x0000_0100, cache data 0..7, mem_cmd_ready_and_i toggling 1/0 -> 8 write cmds at 0x100..0x138 carrying data 0..7; dma_data_yumi_o only when ready.
REQ-028 Read with dma_data_ready_and_i low 5 cycles mid-burst -> mem_resp_ready_and_o low same cycles, no beat lost or duplicated.
REQ-029 Back-to-back packets, read then write, second valid during first -> second yumi no earlier than one IDLE cycle after first completes.
REQ-030 reset_i asserted at read beat 3 -> all outputs 0 next cycle; next packet processed from beat 0 correctly.
